chad_xstack: RTL

CHAD_XSTACK -- requirements
Module: chad_xstack

---
 rtl/chad_xstack.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/chad_xstack.sv
// -----------------------------------------------------------------------------
// chad_xstack -- circular hardware stack with depth tracking and sticky errors
//
// A DEPTH-cell circular stack with a free-running AW-bit pointer. Each
// non-held clock edge moves the pointer by a signed 2-bit delta (+1, 0, -1, -2)
// and can write a new value into the cell that becomes the top after the move.
// The top cell and an arbitrary cell below it ("pick") are read
// combinationally. A separate live-cell counter saturates at 0 and DEPTH and
// raises sticky overflow/underflow flags when an operation would leave that
// range. The pointer itself always moves, so an overflowing push overwrites the
// oldest cell.
//
// Ports
//   clk        in   1      sole clock, rising edge
//   resetq     in   1      asynchronous active-low reset (pointer, count, flags)
//   hold       in   1      freezes all state while high
//   we         in   1      write wd into the post-move top cell
//   wd         in   WIDTH  write data
//   delta      in   2      pointer move: 01=+1, 00=0, 11=-1, 10=-2
//   rd         out  WIDTH  current top cell, combinational
//   pick_idx   in   AW     offset below the top for pick_data
//   pick_data  out  WIDTH  cell at (sp - pick_idx) mod DEPTH, combinational
//   depth      out  AW+1   live cell count, 0..DEPTH
//   clr_err    in   1      clears ovf/unf (a same-edge new error wins)
//   ovf        out  1      sticky overflow
//   unf        out  1      sticky underflow
// -----------------------------------------------------------------------------
module chad_xstack #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             hold,
    input  logic             we,
    input  logic [WIDTH-1:0] wd,
    input  logic [1:0]       delta,
    output logic [WIDTH-1:0] rd,
    input  logic [AW-1:0]    pick_idx,
    output logic [WIDTH-1:0] pick_data,
    output logic [AW:0]      depth,
    input  logic             clr_err,
    output logic             ovf,
    output logic             unf
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // Storage and state
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_sp;
    logic [AW:0]      r_depth;
    logic             r_ovf;
    logic             r_unf;

    // Next-state terms
    logic [AW-1:0]    w_sp_next;
    logic [AW:0]      w_depth_next;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic             w_ovf_next;
    logic             w_unf_next;
    logic [AW-1:0]    w_pick_addr;
    logic             w_wr_en;

    // Pointer move: plain modulo-DEPTH arithmetic, it never saturates.
    always_comb begin
        w_sp_next = r_sp;
        case (delta)
            2'b01:   w_sp_next = r_sp + AW'(1);
            2'b11:   w_sp_next = r_sp - AW'(1);
            2'b10:   w_sp_next = r_sp - AW'(2);
            default: w_sp_next = r_sp;
        endcase
    end

    // Live-count update. The count saturates at both ends; hitting a limit
    // raises the matching error event instead of moving past it.
    always_comb begin
        w_depth_next = r_depth;
        w_ovf_evt    = 1'b0;
        w_unf_evt    = 1'b0;
        case (delta)
            2'b01: begin
                if (r_depth == FULL_COUNT) begin
                    w_ovf_evt = 1'b1;
                end else begin
                    w_depth_next = r_depth + (AW+1)'(1);
                end
            end
            2'b11: begin
                if (r_depth == '0) begin
                    w_unf_evt = 1'b1;
                end else begin
                    w_depth_next = r_depth - (AW+1)'(1);
                end
            end
            2'b10: begin
                if (r_depth < (AW+1)'(2)) begin
                    w_unf_evt    = 1'b1;
                    w_depth_next = '0;
                end else begin
                    w_depth_next = r_depth - (AW+1)'(2);
                end
            end
            default: w_depth_next = r_depth;
        endcase
    end

    // A fresh error on the same edge as clr_err keeps the flag set.
    assign w_ovf_next = (r_ovf & ~clr_err) | w_ovf_evt;
    assign w_unf_next = (r_unf & ~clr_err) | w_unf_evt;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_sp    <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (!hold) begin
            r_sp    <= w_sp_next;
            r_depth <= w_depth_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
        end
    end

    // Memory contents survive reset. Writes are qualified by resetq so an
    // edge that arrives while reset is held cannot commit a pending write.
    assign w_wr_en = resetq & ~hold & we;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            // contents intentionally left untouched
        end else if (w_wr_en) begin
            r_mem[w_sp_next] <= wd;
        end
    end

    // Pick address wraps modulo DEPTH through the AW-bit subtraction.
    assign w_pick_addr = r_sp - pick_idx;

    assign rd        = r_mem[r_sp];
    assign pick_data = r_mem[w_pick_addr];
    assign depth     = r_depth;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

endmodule
